// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback queue in front of the register-file write port.
// Buffers (addr,data) requests, drains at most one per cycle into registered
// we3/wa3/wd3, and optionally forwards pending data to two read ports.
// Optional feature macro: RF_WB_FWD_EN (combinational read forwarding).
module rf_wb_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [AW-1:0]              in_addr,
   input  logic [DW-1:0]              in_data,
   input  logic                       drain_en,
   output logic                       we3,
   output logic [AW-1:0]              wa3,
   output logic [DW-1:0]              wd3,
   input  logic [AW-1:0]              ra1,
   input  logic [AW-1:0]              ra2,
   output logic                       fwd1_hit,
   output logic [DW-1:0]              fwd1_data,
   output logic                       fwd2_hit,
   output logic [DW-1:0]              fwd2_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we3_q;
   logic [AW-1:0] wa3_q;
   logic [DW-1:0] wd3_q;

   logic accept;
   logic store;
   logic pop;

   // Handshake and pointer/count next-state; address 0 completes but is dropped
   always_comb begin
      in_ready = (cnt_q < CW'(DEPTH));
      accept   = in_valid && in_ready;
      store    = accept && (in_addr != '0);
      pop      = drain_en && (cnt_q != '0);
      wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (store && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!store && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Control state and registered regfile write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         we3_q    <= 1'b0;
         wa3_q    <= '0;
         wd3_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         we3_q    <= pop;
         if (pop) begin
            wa3_q <= addr_mem[rd_ptr_q];
            wd3_q <= data_mem[rd_ptr_q];
         end
      end
   end

   // Entry storage; contents are don't-care until covered by the count
   always_ff @(posedge clk) begin
      if (store) begin
         addr_mem[wr_ptr_q] <= in_addr;
         data_mem[wr_ptr_q] <= in_data;
      end
   end

   assign we3   = we3_q;
   assign wa3   = wa3_q;
   assign wd3   = wd3_q;
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

`ifdef RF_WB_FWD_EN
   // Newest match wins: output register first (oldest), then queue oldest->newest overriding
   function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
      logic [DW:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      if (ra != '0) begin
         if (we3_q && (wa3_q == ra)) begin
            res = {1'b1, wd3_q};
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < cnt_q) && (addr_mem[idx] == ra)) begin
               res = {1'b1, data_mem[idx]};
            end
         end
      end
      return res;
   endfunction

   // Forwarding lookup against state only, so same-cycle pushes are invisible
   always_comb begin
      {fwd1_hit, fwd1_data} = lookup(ra1);
      {fwd2_hit, fwd2_data} = lookup(ra2);
   end
`else
   logic unused_ra;
   assign unused_ra = ^{ra1, ra2};
   assign fwd1_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_hit  = 1'b0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: scoreboard bench for rf_wb_queue (DEPTH=4, AW=5, DW=32).
module tb_rf_wb_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          drain_en = 1'b0;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [DW-1:0] wd3;
   logic [AW-1:0] ra1 = '0;
   logic [AW-1:0] ra2 = '0;
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd1_data, fwd2_data;
   logic [2:0]    count;
   logic          empty;

   int checks = 0;
   int failures = 0;
   logic [AW+DW-1:0] exp_q [$];

   rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
      .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit),
      .fwd2_data(fwd2_data), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request; records the expectation at the accepting edge
   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int guard;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      guard = 0;
      while (!in_ready && guard < 50) begin
         step();
         guard++;
      end
      if (!in_ready) check("push_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      if (a != '0) exp_q.push_back({a, d});
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      drain_en = 1'b1;
      for (int i = 0; i < 20 && (count != 0 || we3); i++) step();
      check("drain_empty", 64'(count), 64'(0));
   endtask

   // Monitor: every regfile write must match the oldest outstanding request
   always @(negedge clk) begin
      if (rst_n && we3) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(we3), 64'(0));
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            check("sb_wa3", 64'(wa3), 64'(e[AW+DW-1:DW]));
            check("sb_wd3", 64'(wd3), 64'(e[DW-1:0]));
         end
      end
   end

   initial begin
      logic exp_hit;
      #12;
      rst_n = 1'b1;
      step();
      check("rst_count", 64'(count), 64'(0));
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_we3", 64'(we3), 64'(0));

      // 1: reset mid-stream, with a write in flight and three entries queued
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) push(AW'(20 + i), DW'(32'h100 + i));
      drain_en = 1'b1;
      step();
      check("t1_count_pre", 64'(count), 64'(3));
      check("t1_we3_pre", 64'(we3), 64'(1));
      drain_en = 1'b0;
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t1_count", 64'(count), 64'(0));
      check("t1_we3", 64'(we3), 64'(0));
      check("t1_wa3", 64'(wa3), 64'(0));
      check("t1_wd3", 64'(wd3), 64'(0));
      check("t1_ready", 64'(in_ready), 64'(1));
      check("t1_empty", 64'(empty), 64'(1));
      step();
      rst_n = 1'b1;
      step();

      // 2: single request, write appears after the second edge, for one cycle
      drain_en = 1'b1;
      push(AW'(5), 32'hAAAA0001);
      check("t2_we3_e0", 64'(we3), 64'(0));
      step();
      check("t2_we3_e1", 64'(we3), 64'(1));
      check("t2_wa3", 64'(wa3), 64'(5));
      check("t2_wd3", 64'(wd3), 64'(32'hAAAA0001));
      step();
      check("t2_we3_e2", 64'(we3), 64'(0));

      // 3: fill, hold a fifth request, then back-to-back drain
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) push(AW'(i), DW'(32'h30 + i));
      check("t3_count_full", 64'(count), 64'(4));
      check("t3_ready_full", 64'(in_ready), 64'(0));
      in_valid = 1'b1;
      in_addr  = AW'(9);
      in_data  = 32'h99;
      step();
      check("t3_count_held", 64'(count), 64'(4));
      check("t3_ready_held", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      drain_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("t3_we3", 64'(we3), 64'(1));
         check("t3_wa3", 64'(wa3), 64'(i));
         if (i == 1) check("t3_ready_after_pop", 64'(in_ready), 64'(1));
      end
      step();
      check("t3_we3_done", 64'(we3), 64'(0));

      // 4: address 0 completes the handshake but is never stored or written
      push(AW'(0), 32'hDEAD);
      check("t4_count", 64'(count), 64'(0));
      check("t4_empty", 64'(empty), 64'(1));
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_no_we3", 64'(we3), 64'(0));
      end

      // 5: forwarding picks the newest pending entry for the address
      drain_en = 1'b0;
      push(AW'(7), 32'h11);
      push(AW'(7), 32'h22);
`ifdef RF_WB_FWD_EN
      exp_hit = 1'b1;
`else
      exp_hit = 1'b0;
`endif
      ra1 = AW'(7);
      ra2 = AW'(0);
      #1;
      check("t5_fwd1_hit", 64'(fwd1_hit), 64'(exp_hit));
      check("t5_fwd1_data", 64'(fwd1_data), exp_hit ? 64'(32'h22) : 64'(0));
      check("t5_fwd2_hit_r0", 64'(fwd2_hit), 64'(0));
      check("t5_fwd2_data_r0", 64'(fwd2_data), 64'(0));
      ra2 = AW'(8);
      #1;
      check("t5_fwd2_hit_miss", 64'(fwd2_hit), 64'(0));
      check("t5_fwd2_data_miss", 64'(fwd2_data), 64'(0));
      drain_all();
      ra1 = '0;
      ra2 = '0;

      // 6: sustained push+pop across pointer wrap keeps count constant
      drain_en = 1'b0;
      push(AW'(10), 32'hC00A);
      push(AW'(11), 32'hC00B);
      drain_en = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 3 * DEPTH; k++) begin
         in_addr = AW'(12 + k);
         in_data = DW'(32'hD000 + k);
         @(posedge clk);
         exp_q.push_back({in_addr, in_data});
         #1;
         check("t6_count", 64'(count), 64'(2));
      end
      in_valid = 1'b0;
      drain_all();
      step();
      check("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
